l2_sum_serializer: RTL and testbench
====================================

Name: l2_sum_serializer

Overview:
Consumer end of the L2 adder array's packed result bus. Accepts one packed word of array_size lane sums, each data_width+1 bits wide (72 bits at the defaults). Emits the lanes one per beat, lane 0 first, over a valid/ready stream to the downstream accumulator or activation stage. Lets a wide parallel adder result feed a narrow serial datapath without loss under backpressure.

Parameters:
data_width, 17, operand lane width on the adder side; each output lane is data_width+1 bits
array_size, 4, number of lanes per packed word
idx_width, 2, width of out_idx; must satisfy 2**idx_width >= array_size

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
in_valid  in  1  packed word available
in_ready  out  1  block can accept a word this cycle
in_word  in  array_size*(data_width+1)  packed sums; lane i occupies bits [(i+1)*(data_width+1)-1 : i*(data_width+1)]
out_valid  out  1  out_lane holds a valid beat
out_ready  in  1  downstream accepts the beat
out_lane  out  data_width+1  current lane value, unsigned, unmodified
out_idx  out  idx_width  lane index of the current beat
out_last  out  1  current beat is the final beat of the word
busy  out  1  a word is held (state SHIFT)

Behaviour:
- Reset (asynchronous, takes effect immediately without a clock edge): state IDLE, in_ready=1, out_valid=0, out_lane=0, out_idx=0, out_last=0, busy=0, word register and lane counter cleared.
- FSM states: IDLE and SHIFT.
- IDLE: in_ready=1. When in_valid=1, register in_word, go to SHIFT, set index 0. in_word is sampled only on acceptance.
- Latency: first beat is valid on the cycle after acceptance (out_valid=1, out_idx=0, out_lane=lane 0).
- SHIFT: a beat transfers when out_valid & out_ready.
  - While out_valid=1 and out_ready=0, out_lane, out_idx and out_last hold stable. No beat is dropped or repeated.
- On transfer of a non-last beat, advance to the next lane on the next cycle. No bubble when out_ready stays high.
- out_last=1 only when out_idx==array_size-1 (see the optional feature for the exception).
- in_ready = IDLE | (SHIFT & out_valid & out_last & out_ready). This is combinational on out_ready.
- On last-beat transfer:
  - If in_valid=1 in the same cycle, load the new word and present its lane 0 on the next cycle. Zero-bubble back-to-back.
  - Otherwise, go to IDLE and drop out_valid.
- Throughput: array_size beats per word with out_ready held high, and continuous across words.
- Reset mid-word: the held word is discarded. The next accepted word starts at index 0.
- No arithmetic: lane bits pass through unchanged. Width consistency: the in_word width is exactly array_size*(data_width+1).

Optional Feature:
Macro L2_SERIALIZER_ZERO_SKIP_EN.
- Defined:
  - Lanes equal to zero are not emitted. out_idx still reports the original lane index.
  - out_last is asserted on the highest-index nonzero lane, computed from a remaining-nonzero mask captured at load.
  - An all-zero word is accepted and produces no beats; in_ready=1 on the following cycle.
  - The back-to-back rule applies at the last nonzero beat.
- Undefined: every lane is emitted in order 0..array_size-1. The zero-detect logic is not synthesized.

Test Plan:
1. Assert reset at an arbitrary time with no clock edge -> immediately in_ready=1, out_valid=0, busy=0, out_lane=0, out_idx=0, out_last=0.
2. Single word, lanes 0..3 = 18'h00001, 18'h2ABCD, 18'h00002, 18'h3FFFF, out_ready=1 -> on cycles 1-4 after acceptance, out_lane=00001/2ABCD/00002/3FFFF, out_idx=0/1/2/3, out_last only on idx 3, then IDLE.
3. Same word with out_ready=0 for 3 cycles while idx 1 is presented -> out_lane holds 18'h2ABCD and out_idx holds 1 throughout; exactly 4 beats total, no duplicates.
4. Two words with in_valid held high and out_ready=1 -> 8 consecutive beats with no gap; in_ready=1 only in the cycle of the first word's idx-3 transfer; second word starts at idx 0.
5. Async reset after the idx-1 transfer of a word -> out_valid=0 at once; the next word emits idx 0..3 fully.
6. With L2_SERIALIZER_ZERO_SKIP_EN defined:
   - Lanes 0..3 = 7, 0, 5, 0 -> two beats: (7, idx 0) then (5, idx 2, out_last=1).
   - All-zero word -> no beats, in_ready=1 on the next cycle.

Source files
------------

// File: rtl/l2_sum_serializer.sv
// Serializes one packed word of lane sums into a lane-per-beat valid/ready stream.
// Optional macro L2_SERIALIZER_ZERO_SKIP_EN suppresses beats for all-zero lanes.
module l2_sum_serializer #(
    parameter int data_width = 17,
    parameter int array_size = 4,
    parameter int idx_width  = 2
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [array_size*(data_width+1)-1:0] in_word,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [data_width:0]                out_lane,
    output logic [idx_width-1:0]               out_idx,
    output logic                               out_last,
    output logic                               busy
);

    localparam int LANE_W = data_width + 1;
    localparam int WORD_W = array_size * LANE_W;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [WORD_W-1:0]     r_word;
    logic [WORD_W-1:0]     w_word_nxt;
    logic [WORD_W-1:0]     w_src_word;
    logic [array_size-1:0] r_mask;
    logic [array_size-1:0] w_mask_nxt;
    logic [array_size-1:0] w_in_mask;
    logic [array_size-1:0] w_src_mask;
    logic [array_size-1:0] w_rem_mask;
    logic [LANE_W-1:0]     r_lane;
    logic [LANE_W-1:0]     w_lane_nxt;
    logic [idx_width-1:0]  r_idx;
    logic [idx_width-1:0]  w_idx_nxt;
    logic [idx_width-1:0]  w_next_idx;
    logic                  r_last;
    logic                  w_last_nxt;
    logic                  r_valid;
    logic                  w_valid_nxt;
    logic                  w_in_ready;
    logic                  w_accept;
    logic                  w_xfer;
    logic                  w_advance;

    function automatic logic [idx_width-1:0] first_set(input logic [array_size-1:0] m);
        first_set = '0;
        for (int i = array_size - 1; i >= 0; i--) begin
            if (m[i]) first_set = idx_width'(i);
        end
    endfunction

    function automatic logic [LANE_W-1:0] lane_of(input logic [WORD_W-1:0] word,
                                                  input logic [idx_width-1:0] idx);
        lane_of = word[int'(idx)*LANE_W +: LANE_W];
    endfunction

    // Lanes eligible for emission; every lane when zero skipping is not built
    always_comb begin
        w_in_mask = '0;
        for (int i = 0; i < array_size; i++) begin
`ifdef L2_SERIALIZER_ZERO_SKIP_EN
            w_in_mask[i] = |in_word[i*LANE_W +: LANE_W];
`else
            w_in_mask[i] = 1'b1;
`endif
        end
    end

    // Input handshake: open in IDLE or while the final beat is being taken
    always_comb begin
        case (r_state)
            IDLE:    w_in_ready = 1'b1;
            SHIFT:   w_in_ready = r_valid & r_last & out_ready;
            default: w_in_ready = 1'b1;
        endcase
    end

    assign w_accept   = in_valid & w_in_ready;
    assign w_xfer     = r_valid & out_ready;
    assign w_advance  = w_accept | (w_xfer & ~r_last);
    assign w_src_word = w_accept ? in_word : r_word;
    assign w_src_mask = w_accept ? w_in_mask : r_mask;
    assign w_next_idx = first_set(w_src_mask);

    // Remaining lanes after the one about to be presented
    always_comb begin
        w_rem_mask             = w_src_mask;
        w_rem_mask[w_next_idx] = 1'b0;
    end

    // Next-state and next-beat selection
    always_comb begin
        w_state_nxt = r_state;
        w_valid_nxt = r_valid;
        w_lane_nxt  = r_lane;
        w_idx_nxt   = r_idx;
        w_last_nxt  = r_last;
        w_mask_nxt  = r_mask;
        w_word_nxt  = w_src_word;
        if (w_advance && (w_src_mask != '0)) begin
            w_state_nxt = SHIFT;
            w_valid_nxt = 1'b1;
            w_lane_nxt  = lane_of(w_src_word, w_next_idx);
            w_idx_nxt   = w_next_idx;
            w_last_nxt  = (w_rem_mask == '0);
            w_mask_nxt  = w_rem_mask;
        end else if (w_accept || (w_xfer && r_last)) begin
            // Word finished (or accepted with nothing to emit): back to IDLE
            w_state_nxt = IDLE;
            w_valid_nxt = 1'b0;
            w_lane_nxt  = '0;
            w_idx_nxt   = '0;
            w_last_nxt  = 1'b0;
            w_mask_nxt  = '0;
        end else begin
            w_state_nxt = r_state;
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    // Word, mask and registered beat outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_word  <= '0;
            r_mask  <= '0;
            r_lane  <= '0;
            r_idx   <= '0;
            r_last  <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_word  <= w_word_nxt;
            r_mask  <= w_mask_nxt;
            r_lane  <= w_lane_nxt;
            r_idx   <= w_idx_nxt;
            r_last  <= w_last_nxt;
            r_valid <= w_valid_nxt;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_valid;
    assign out_lane  = r_lane;
    assign out_idx   = r_idx;
    assign out_last  = r_last;
    assign busy      = (r_state == SHIFT);

endmodule

// File: tb/tb_l2_sum_serializer.sv
// Directed self-checking bench for l2_sum_serializer (inputs driven and outputs sampled on negedge).
module tb_l2_sum_serializer;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [71:0] in_word;
    logic        out_valid;
    logic        out_ready;
    logic [17:0] out_lane;
    logic [1:0]  out_idx;
    logic        out_last;
    logic        busy;

    int n_checks;
    int n_fail;
    int beat_cnt;
    int b0;

    l2_sum_serializer #(.data_width(17), .array_size(4), .idx_width(2)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_word(in_word), .out_valid(out_valid), .out_ready(out_ready),
        .out_lane(out_lane), .out_idx(out_idx), .out_last(out_last), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial beat_cnt = 0;
    always @(posedge clk) begin
        if (!reset && out_valid && out_ready) beat_cnt <= beat_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic check_beat(input string tag, input logic [17:0] lane,
                              input logic [1:0] idx, input logic last);
        check_eq({tag, "_valid"}, 32'(out_valid), 32'd1);
        check_eq({tag, "_lane"},  32'(out_lane),  32'(lane));
        check_eq({tag, "_idx"},   32'(out_idx),   32'(idx));
        check_eq({tag, "_last"},  32'(out_last),  32'(last));
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, "_valid"},    32'(out_valid), 32'd0);
        check_eq({tag, "_busy"},     32'(busy),      32'd0);
        check_eq({tag, "_in_ready"}, 32'(in_ready),  32'd1);
        check_eq({tag, "_lane"},     32'(out_lane),  32'd0);
        check_eq({tag, "_idx"},      32'(out_idx),   32'd0);
        check_eq({tag, "_last"},     32'(out_last),  32'd0);
    endtask

    function automatic logic [71:0] pack4(input logic [17:0] l0, input logic [17:0] l1,
                                          input logic [17:0] l2, input logic [17:0] l3);
        pack4 = {l3, l2, l1, l0};
    endfunction

    logic [17:0] wa [4];
    logic [17:0] wb [4];

    initial begin
        n_checks = 0;
        n_fail   = 0;
        wa[0] = 18'h00001; wa[1] = 18'h2ABCD; wa[2] = 18'h00002; wa[3] = 18'h3FFFF;
        wb[0] = 18'h12345; wb[1] = 18'h0ABCD; wb[2] = 18'h3F000; wb[3] = 18'h00010;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_word = 72'd0;
        #3;
        check_idle("reset_init");
        @(negedge clk); @(negedge clk);
        reset = 1'b0;

        // Single word, free-flowing output
        in_word = pack4(wa[0], wa[1], wa[2], wa[3]); in_valid = 1'b1; out_ready = 1'b1;
        b0 = beat_cnt;
        @(negedge clk); in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_beat("single", wa[i], 2'(i), i == 3);
            @(negedge clk);
        end
        check_idle("single_end");
        check_eq("single_beats", 32'(beat_cnt - b0), 32'd4);

        // Backpressure while idx 1 is presented
        in_valid = 1'b1; b0 = beat_cnt;
        @(negedge clk); in_valid = 1'b0;
        check_beat("bp0", wa[0], 2'd0, 1'b0);
        @(negedge clk); out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check_beat("bp_hold", wa[1], 2'd1, 1'b0);
            check_eq("bp_busy", 32'(busy), 32'd1);
            @(negedge clk);
        end
        check_beat("bp_hold_last", wa[1], 2'd1, 1'b0);
        out_ready = 1'b1;
        @(negedge clk);
        check_beat("bp2", wa[2], 2'd2, 1'b0);
        @(negedge clk);
        check_beat("bp3", wa[3], 2'd3, 1'b1);
        @(negedge clk);
        check_idle("bp_end");
        check_eq("bp_beats", 32'(beat_cnt - b0), 32'd4);

        // Back-to-back words, in_valid held high
        in_word = pack4(wa[0], wa[1], wa[2], wa[3]); in_valid = 1'b1; b0 = beat_cnt;
        @(negedge clk);
        in_word = pack4(wb[0], wb[1], wb[2], wb[3]);
        for (int i = 0; i < 4; i++) begin
            check_beat("b2b_a", wa[i], 2'(i), i == 3);
            check_eq("b2b_a_in_ready", 32'(in_ready), 32'(i == 3));
            @(negedge clk);
        end
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_beat("b2b_b", wb[i], 2'(i), i == 3);
            @(negedge clk);
        end
        check_idle("b2b_end");
        check_eq("b2b_beats", 32'(beat_cnt - b0), 32'd8);

        // Asynchronous reset mid-word, then a fresh word
        in_word = pack4(wb[0], wb[1], wb[2], wb[3]); in_valid = 1'b1;
        @(negedge clk); in_valid = 1'b0;
        check_beat("rst_pre0", wb[0], 2'd0, 1'b0);
        @(negedge clk);
        check_beat("rst_pre1", wb[1], 2'd1, 1'b0);
        @(negedge clk);
        #2 reset = 1'b1;
        #1 check_idle("rst_async");
        @(negedge clk); reset = 1'b0;
        in_word = pack4(wa[0], wa[1], wa[2], wa[3]); in_valid = 1'b1; b0 = beat_cnt;
        @(negedge clk); in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_beat("rst_post", wa[i], 2'(i), i == 3);
            @(negedge clk);
        end
        check_idle("rst_post_end");
        check_eq("rst_post_beats", 32'(beat_cnt - b0), 32'd4);

`ifdef L2_SERIALIZER_ZERO_SKIP_EN
        // Zero lanes skipped, original indices reported
        in_word = pack4(18'd7, 18'd0, 18'd5, 18'd0); in_valid = 1'b1; b0 = beat_cnt;
        @(negedge clk); in_valid = 1'b0;
        check_beat("zs0", 18'd7, 2'd0, 1'b0);
        @(negedge clk);
        check_beat("zs2", 18'd5, 2'd2, 1'b1);
        @(negedge clk);
        check_idle("zs_end");
        check_eq("zs_beats", 32'(beat_cnt - b0), 32'd2);

        // All-zero word: accepted, nothing emitted
        in_word = 72'd0; in_valid = 1'b1; b0 = beat_cnt;
        check_eq("zs_all_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk); in_valid = 1'b0;
        check_idle("zs_all_next");
        @(negedge clk); @(negedge clk);
        check_eq("zs_all_beats", 32'(beat_cnt - b0), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
